// File: rtl/ifu_fetch.sv
// Fetch stage: holds the PC and issues one imem request at a time, then presents {instr, pc} to decode.
// Latency: REQ -> WAIT (>=1 cycle) -> FULL, so at most one instruction every 3 cycles.
// Backpressure: the held instruction waits in FULL until decode takes it; a stalled imem holds REQ with a stable address.
module ifu_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FULL = 2'd3
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic              drop, drop_nxt;
    logic [31:0]       instr_q, instr_nxt;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_nxt;
    logic [ADDR_W-1:0] redirect_tgt;

    assign redirect_tgt = redirect_pc & ~ADDR_W'(3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            drop       <= 1'b0;
            instr_q    <= NOP;
            instr_pc_q <= RESET_PC;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            drop       <= drop_nxt;
            instr_q    <= instr_nxt;
            instr_pc_q <= instr_pc_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        drop_nxt     = drop;
        instr_nxt    = instr_q;
        instr_pc_nxt = instr_pc_q;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (imem_req_ready) begin
                    state_nxt = WAIT;
                    // request already left with the stale pc: its response must be thrown away
                    drop_nxt  = redirect_valid;
                end
                if (redirect_valid) pc_nxt = redirect_tgt;
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    drop_nxt = 1'b0;
                    if (drop || redirect_valid) begin
                        state_nxt = REQ;
                    end else begin
                        state_nxt    = FULL;
                        instr_nxt    = imem_rsp_data;
                        instr_pc_nxt = pc;
                    end
                end else if (redirect_valid) begin
                    drop_nxt = 1'b1;
                end
                if (redirect_valid) pc_nxt = redirect_tgt;
            end
            FULL: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_tgt;
                    state_nxt = REQ;
                end else if (instr_ready) begin
                    pc_nxt    = pc + ADDR_W'(4);
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pc;
    assign instr_valid    = (state == FULL);
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomised bench for ifu_fetch: a responder plays imem, a queue of expected PCs tracks the architectural stream.
module tb_ifu_fetch;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk, rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    ifu_fetch #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk = 0, n_fail = 0;
    logic [31:0] exp_q[$];
    int          acc_cnt = 0, acc_seen = 0, dlv_cnt = 0;
    logic [31:0] acc_addr, mpc;
    logic        pend = 1'b0, just_acc = 1'b0;
    int          cnt = 0, force_delay = -1;
    logic [31:0] paddr;
    logic        force_data_en = 1'b0;
    int          rdy_mode = 2, req_mode = 2;

    // Instruction image: every word is a fixed function of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard, evaluated mid-cycle once inputs for the next edge are settled.
    initial forever begin
        @(negedge clk);
        #2;
        if (!rst) begin
            exp_q.delete();
            exp_q.push_back(RESET_PC);
            check("rst_instr_valid", 32'(instr_valid), 32'd0);
            check("rst_req_valid", 32'(imem_req_valid), 32'd0);
            check("rst_instr", instr, 32'h0000_0013);
            check("rst_instr_pc", instr_pc, RESET_PC);
        end else begin
            check("req_and_full", 32'(imem_req_valid & instr_valid), 32'd0);
            if (pend) check("req_while_pending", 32'(imem_req_valid), 32'd0);
            if (imem_req_valid && imem_req_ready) begin
                acc_cnt++;
                acc_addr = imem_req_addr;
                if (!redirect_valid) check("req_addr", imem_req_addr, exp_q[0]);
            end
            if (redirect_valid) begin
                exp_q.delete();
                exp_q.push_back(redirect_pc & ~32'h3);
            end else if (instr_valid) begin
                check("instr_pc", instr_pc, exp_q[0]);
                check("instr", instr, mem_word(exp_q[0]));
                if (instr_ready) begin
                    mpc = exp_q.pop_front();
                    exp_q.push_back(mpc + 32'd4);
                    dlv_cnt++;
                end
            end
        end
    end

    // One clock of stimulus: imem responder plus randomised handshakes.
    task automatic cycle(input logic redir, input logic [31:0] tgt);
        @(negedge clk);
        just_acc = 1'b0;
        if (acc_seen != acc_cnt) begin
            acc_seen = acc_cnt;
            just_acc = 1'b1;
            pend     = 1'b1;
            cnt      = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 2));
            paddr    = acc_addr;
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (pend) begin
            if (cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = force_data_en ? 32'h0050_0093 : mem_word(paddr);
                pend           = 1'b0;
            end else begin
                cnt--;
            end
        end
        imem_req_ready = (req_mode == 0) ? ($urandom_range(0, 3) != 0) : (req_mode == 2);
        instr_ready    = (rdy_mode == 0) ? 1'($urandom_range(0, 1)) : (rdy_mode == 2);
        redirect_valid = redir;
        redirect_pc    = tgt;
    endtask

    task automatic wait_full();
        int k = 0;
        cycle(1'b0, 32'h0);
        while (!instr_valid && k < 60) begin
            cycle(1'b0, 32'h0);
            k++;
        end
        check("wait_full_timeout", 32'(instr_valid), 32'd1);
    endtask

    task automatic wait_acc();
        int k = 0;
        cycle(1'b0, 32'h0);
        while (!just_acc && k < 60) begin
            cycle(1'b0, 32'h0);
            k++;
        end
        check("wait_acc_timeout", 32'(just_acc), 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Straight-line fetch from RESET_PC with everything ready.
        repeat (20) cycle(1'b0, 32'h0);
        rdy_mode = 0; req_mode = 0;

        // Decode stall for 5 cycles while FULL, then release.
        wait_full();
        instr_ready = 1'b0;
        rdy_mode = 1;
        repeat (5) cycle(1'b0, 32'h0);
        rdy_mode = 2;
        repeat (10) cycle(1'b0, 32'h0);
        rdy_mode = 0;

        // Redirect while WAIT, response arrives two cycles later and must be dropped.
        force_delay = 2;
        wait_acc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        force_data_en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0);
            check("drop_no_valid", 32'(instr_valid), 32'd0);
        end
        force_data_en = 1'b0;
        force_delay   = -1;
        repeat (15) cycle(1'b0, 32'h0);

        // Redirect in FULL together with instr_ready: target wins over pc+4.
        wait_full();
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_4000;
        repeat (15) cycle(1'b0, 32'h0);

        // PC wrap from the top of the address space.
        cycle(1'b1, 32'hFFFF_FFFC);
        rdy_mode = 2;
        repeat (25) cycle(1'b0, 32'h0);
        rdy_mode = 0;

        // Random traffic with occasional redirects.
        repeat (2000) cycle($urandom_range(0, 99) < 6, $urandom);

        // Reset while WAIT; stale responses right after release must be ignored.
        force_delay = 3;
        wait_acc();
        force_delay = -1;
        rst = 1'b0;
        pend = 1'b0;
        acc_seen = acc_cnt;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        instr_ready = 1'b0; redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rsp_valid = 1'b1;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        repeat (40) cycle(1'b0, 32'h0);

        check("progress", 32'(dlv_cnt > 100), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
